aes_dec_sched: RTL

- Schedules one shared aes_decipher_block engine between two requesters.
- Arbitrates between two request ports with round-robin priority and issues one `next` pulse per accepted request.
- Routes the engine's round index to an external round-key memory, selecting that requester's key set.
- Captures the deciphered block and returns it on a valid/ready response port tagged with the requester id. A watchdog turns a hung engine into an error response.

---
 rtl/aes_dec_sched.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/aes_dec_sched.sv
// aes_dec_sched: shares one AES decipher engine between two requesters.
// Round-robin arbitration, one engine start per accepted request, round-key
// routing to the owner's key set, and a watchdog that converts a hung engine
// into an error response.
module aes_dec_sched #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CW             = 8
) (
    input  logic         clk,
    input  logic         reset_n,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [127:0] req0_block,
    input  logic         req0_keylen,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [127:0] req1_block,
    input  logic         req1_keylen,

    output logic         resp_valid,
    input  logic         resp_ready,
    output logic         resp_id,
    output logic [127:0] resp_block,
    output logic         resp_err,

    output logic         dec_next,
    output logic         dec_keylen,
    output logic [127:0] dec_block,
    input  logic         dec_ready,
    input  logic [127:0] dec_new_block,
    input  logic [3:0]   dec_round,
    output logic [127:0] dec_round_key,

    output logic         key_sel,
    output logic [3:0]   key_round,
    input  logic [127:0] key_rdata
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } state_t;

    // Watchdog fires on the last counted cycle, so the engine gets exactly
    // TIMEOUT_CYCLES cycles in WAIT_BUSY+WAIT_DONE.
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t        state_reg;
    logic          owner_reg;
    logic          kl_reg;
    logic          rr_last_reg;
    logic [127:0]  blk_reg;
    logic          dec_next_reg;
    logic          resp_valid_reg;
    logic          resp_err_reg;
    logic [127:0]  resp_block_reg;
    logic [CW-1:0] wd_cnt_reg;

    logic          grant0;
    logic          grant1;
    logic          wd_expired;

    // Round-robin grant: a lone requester wins; on a tie the one that was not
    // served last wins.
    always_comb begin
        grant0 = req0_valid & (~req1_valid | rr_last_reg);
        grant1 = req1_valid & (~req0_valid | ~rr_last_reg);
    end

    assign req0_ready    = (state_reg == IDLE) & grant0;
    assign req1_ready    = (state_reg == IDLE) & grant1;
    assign wd_expired    = (wd_cnt_reg == WD_LAST);

    assign dec_next      = dec_next_reg;
    assign dec_block     = blk_reg;
    assign dec_keylen    = kl_reg;
    assign key_sel       = owner_reg;
    assign key_round     = dec_round;
    assign dec_round_key = key_rdata;

    assign resp_valid    = resp_valid_reg;
    assign resp_id       = owner_reg;
    assign resp_block    = resp_block_reg;
    assign resp_err      = resp_err_reg;

    // Scheduler FSM with registered start pulse, watchdog and response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            owner_reg      <= 1'b0;
            kl_reg         <= 1'b0;
            rr_last_reg    <= 1'b1;
            blk_reg        <= '0;
            dec_next_reg   <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_block_reg <= '0;
            wd_cnt_reg     <= '0;
        end else begin
            dec_next_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req0_ready) begin
                        blk_reg      <= req0_block;
                        kl_reg       <= req0_keylen;
                        owner_reg    <= 1'b0;
                        rr_last_reg  <= 1'b0;
                        dec_next_reg <= 1'b1;
                        state_reg    <= START;
                    end else if (req1_ready) begin
                        blk_reg      <= req1_block;
                        kl_reg       <= req1_keylen;
                        owner_reg    <= 1'b1;
                        rr_last_reg  <= 1'b1;
                        dec_next_reg <= 1'b1;
                        state_reg    <= START;
                    end
                end
                START: begin
                    wd_cnt_reg <= '0;
                    state_reg  <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // Ready is still high from the previous idle period here;
                    // only its fall tells us the engine has started.
                    if (wd_expired) begin
                        resp_block_reg <= '0;
                        resp_err_reg   <= 1'b1;
                        resp_valid_reg <= 1'b1;
                        state_reg      <= RESP;
                    end else begin
                        wd_cnt_reg <= wd_cnt_reg + 1'b1;
                        if (!dec_ready) begin
                            state_reg <= WAIT_DONE;
                        end
                    end
                end
                WAIT_DONE: begin
                    // A result arriving on the final watchdog cycle still wins.
                    if (dec_ready) begin
                        resp_block_reg <= dec_new_block;
                        resp_err_reg   <= 1'b0;
                        resp_valid_reg <= 1'b1;
                        state_reg      <= RESP;
                    end else if (wd_expired) begin
                        resp_block_reg <= '0;
                        resp_err_reg   <= 1'b1;
                        resp_valid_reg <= 1'b1;
                        state_reg      <= RESP;
                    end else begin
                        wd_cnt_reg <= wd_cnt_reg + 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_reg <= 1'b0;
                        state_reg      <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
